// File: rtl/trap_arbiter_if.sv
// CSR/irq/debug inputs and the trap valid/ready handshake between the arbiter and the commit stage.
// The arbiter takes the master side; the commit/CSR logic takes the slave side.
interface trap_arbiter_if #(
    parameter int XLEN   = 64,
    parameter int NLOCAL = 16
);
    localparam int NI = 16 + NLOCAL;

    logic [1:0]      priv;
    logic            debug_mode;
    logic            csr_mstatus_mie;
    logic            csr_sstatus_sie;
    logic [XLEN-1:0] csr_mie;
    logic [XLEN-1:0] csr_mip_sw;
    logic [XLEN-1:0] csr_mideleg;
    logic [XLEN-1:0] csr_medeleg;
    logic [NI-1:0]   irq;
    logic            nmi;
    logic            exc_valid;
    logic [5:0]      exc_cause;
    logic            ebreak;
    logic            instr_retire;
    logic            haltreq;
    logic            dcsr_step;
    logic            dcsr_ebreakm;
    logic            dcsr_ebreaks;
    logic            dcsr_ebreaku;
    logic            trap_valid;
    logic            trap_ready;
    logic [1:0]      trap_target;
    logic [XLEN-1:0] trap_cause;
    logic [3:0]      trap_dcause;
    logic [NI-1:0]   pending_o;

    modport master (
        input  priv, debug_mode, csr_mstatus_mie, csr_sstatus_sie,
        input  csr_mie, csr_mip_sw, csr_mideleg, csr_medeleg,
        input  irq, nmi, exc_valid, exc_cause, ebreak, instr_retire,
        input  haltreq, dcsr_step, dcsr_ebreakm, dcsr_ebreaks, dcsr_ebreaku,
        input  trap_ready,
        output trap_valid, trap_target, trap_cause, trap_dcause, pending_o
    );

    modport slave (
        output priv, debug_mode, csr_mstatus_mie, csr_sstatus_sie,
        output csr_mie, csr_mip_sw, csr_mideleg, csr_medeleg,
        output irq, nmi, exc_valid, exc_cause, ebreak, instr_retire,
        output haltreq, dcsr_step, dcsr_ebreakm, dcsr_ebreaks, dcsr_ebreaku,
        output trap_ready,
        input  trap_valid, trap_target, trap_cause, trap_dcause, pending_o
    );
endinterface

// File: rtl/trap_arbiter.sv
// Registered trap arbiter: debug > exception > NMI > interrupts, one decision in flight.
// trap_valid one cycle after a valid decision; held stable in HOLD until trap_ready, then one FLUSH cycle.
module trap_arbiter #(
    parameter int                   XLEN        = 64,
    parameter int                   NLOCAL      = 16,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [16+NLOCAL-1:0] EDGE_MASK   = '0
) (
    input  logic           clk,
    input  logic           arst,
    trap_arbiter_if.master bus
);
    localparam int NI = 16 + NLOCAL;
    localparam logic [1:0] PRV_M = 2'b11, PRV_S = 2'b01, PRV_U = 2'b00, TGT_DBG = 2'b10;
    localparam logic [3:0] DC_NONE = 4'd0, DC_EBREAK = 4'd1, DC_HALT = 4'd3, DC_STEP = 4'd4;
    // Element 0 is the lowest-priority standard cause; later matches override earlier ones.
    localparam logic [5:0][7:0] STD_ORDER = {8'd11, 8'd3, 8'd7, 8'd9, 8'd1, 8'd5};

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} state_t;
    typedef enum logic [1:0] {S_OFF, S_ARM, S_FIRE} step_t;

    state_t          r_state, w_state_nxt;
    step_t           r_step, w_step_nxt;
    logic [NI:0]     w_raw, w_sync, r_prev, w_rise;
    logic [NI-1:0]   r_latch, w_pend, w_s_tgt, w_take, w_int_oh, w_dec_clr, r_clr_vec;
    logic            r_nmi, w_nmi_pend, r_dbg_q, w_hs, w_m_ok, w_s_ok;
    logic            w_ebreak_dbg, w_step_fire, w_exc_s;
    logic            w_int_vld, w_int_s, w_dec_vld, w_dec_nmi, r_clr_nmi;
    logic [XLEN-1:0] w_int_cause, w_dec_cause, r_cause;
    logic [1:0]      w_dec_tgt, r_tgt;
    logic [3:0]      w_dec_dcause, r_dcause;

    assign w_raw = {bus.nmi, bus.irq};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = w_raw;
        end else begin : g_sync
            logic [NI:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
                end else begin
                    r_sync[0] <= w_raw;
                    for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
                end
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_rise = w_sync & ~r_prev;
    assign w_hs   = (r_state == ST_HOLD) & bus.trap_ready;

    // A fresh rising edge wins over the clear of an accepted trap in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_prev  <= '0;
            r_latch <= '0;
            r_nmi   <= 1'b0;
            r_dbg_q <= 1'b0;
        end else begin
            r_prev  <= w_sync;
            r_latch <= ((r_latch & ~(w_hs ? r_clr_vec : '0)) | w_rise[NI-1:0]) & EDGE_MASK;
            r_nmi   <= (r_nmi & ~(w_hs & r_clr_nmi)) | w_rise[NI];
            r_dbg_q <= bus.debug_mode;
        end
    end

    assign w_pend = ((w_sync[NI-1:0] | bus.csr_mip_sw[NI-1:0]) & ~EDGE_MASK)
                  | ((r_latch | w_rise[NI-1:0] | bus.csr_mip_sw[NI-1:0]) & EDGE_MASK);
    assign w_nmi_pend    = r_nmi | w_rise[NI];
    assign bus.pending_o = w_pend;

    assign w_m_ok  = (bus.priv != PRV_M) | bus.csr_mstatus_mie;
    assign w_s_ok  = (bus.priv == PRV_U) | ((bus.priv == PRV_S) & bus.csr_sstatus_sie);
    assign w_s_tgt = {NI{bus.priv != PRV_M}} & bus.csr_mideleg[NI-1:0];
    assign w_take  = w_pend & bus.csr_mie[NI-1:0]
                   & ((w_s_tgt & {NI{w_s_ok}}) | (~w_s_tgt & {NI{w_m_ok}}));

    always_comb begin
        logic [NI-1:0] oh;
        oh          = '0;
        w_int_vld   = 1'b0;
        w_int_oh    = '0;
        w_int_cause = '0;
        for (int j = 16; j < NI; j++) begin
            oh = NI'(1) << j;
            if (|(w_take & oh)) begin
                w_int_vld   = 1'b1;
                w_int_oh    = oh;
                w_int_cause = XLEN'(j);
            end
        end
        for (int k = 0; k < 6; k++) begin
            oh = NI'(1) << STD_ORDER[k];
            if (|(w_take & oh)) begin
                w_int_vld   = 1'b1;
                w_int_oh    = oh;
                w_int_cause = XLEN'(STD_ORDER[k]);
            end
        end
        w_int_s                 = |(w_s_tgt & w_int_oh);
        w_int_cause[XLEN-1]     = w_int_vld;
    end

    always_comb begin
        w_ebreak_dbg = 1'b0;
        case (bus.priv)
            PRV_M:   w_ebreak_dbg = bus.ebreak & bus.dcsr_ebreakm;
            PRV_S:   w_ebreak_dbg = bus.ebreak & bus.dcsr_ebreaks;
            PRV_U:   w_ebreak_dbg = bus.ebreak & bus.dcsr_ebreaku;
            default: w_ebreak_dbg = 1'b0;
        endcase
    end

    assign w_exc_s     = (bus.priv != PRV_M) & (|(bus.csr_medeleg & (XLEN'(1) << bus.exc_cause)));
    assign w_step_fire = (r_step == S_FIRE) | ((r_step == S_ARM) & bus.instr_retire);

    always_comb begin
        w_dec_vld    = 1'b0;
        w_dec_tgt    = PRV_M;
        w_dec_cause  = '0;
        w_dec_dcause = DC_NONE;
        w_dec_clr    = '0;
        w_dec_nmi    = 1'b0;
        if (!bus.debug_mode && (bus.haltreq || w_step_fire || w_ebreak_dbg)) begin
            w_dec_vld    = 1'b1;
            w_dec_tgt    = TGT_DBG;
            w_dec_dcause = bus.haltreq ? DC_HALT : (w_step_fire ? DC_STEP : DC_EBREAK);
        end else if (bus.exc_valid) begin
            w_dec_vld   = 1'b1;
            w_dec_tgt   = w_exc_s ? PRV_S : PRV_M;
            w_dec_cause = XLEN'(bus.exc_cause);
        end else if (!bus.debug_mode && w_nmi_pend) begin
            w_dec_vld             = 1'b1;
            w_dec_cause[XLEN-1]   = 1'b1;
            w_dec_nmi             = 1'b1;
        end else if (!bus.debug_mode && w_int_vld) begin
            w_dec_vld   = 1'b1;
            w_dec_tgt   = w_int_s ? PRV_S : PRV_M;
            w_dec_cause = w_int_cause;
            w_dec_clr   = w_int_oh;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_dec_vld) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.trap_ready) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Step request persists in S_FIRE until any debug trap is accepted.
    always_comb begin
        w_step_nxt = r_step;
        case (r_step)
            S_OFF:   if (bus.dcsr_step && r_dbg_q && !bus.debug_mode) w_step_nxt = S_ARM;
            S_ARM:   if (bus.instr_retire) w_step_nxt = S_FIRE;
            S_FIRE:  if (w_hs && (r_tgt == TGT_DBG)) w_step_nxt = S_OFF;
            default: w_step_nxt = S_OFF;
        endcase
        if (!bus.dcsr_step) w_step_nxt = S_OFF;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_step  <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tgt     <= PRV_M;
            r_cause   <= '0;
            r_dcause  <= DC_NONE;
            r_clr_vec <= '0;
            r_clr_nmi <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_dec_vld) begin
            r_tgt     <= w_dec_tgt;
            r_cause   <= w_dec_cause;
            r_dcause  <= w_dec_dcause;
            r_clr_vec <= w_dec_clr;
            r_clr_nmi <= w_dec_nmi;
        end
    end

    assign bus.trap_valid  = (r_state == ST_HOLD);
    assign bus.trap_target = r_tgt;
    assign bus.trap_cause  = r_cause;
    assign bus.trap_dcause = r_dcause;
endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter: priorities, latching, handshake, debug step/halt, async reset.
module tb_trap_arbiter;
    localparam int XLEN = 64, NLOCAL = 16;
    localparam logic [1:0] M = 2'b11, S = 2'b01, U = 2'b00, D = 2'b10;

    logic clk = 1'b0;
    logic arst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    trap_arbiter_if #(.XLEN(XLEN), .NLOCAL(NLOCAL)) bus ();

    trap_arbiter #(
        .XLEN(XLEN), .NLOCAL(NLOCAL), .SYNC_STAGES(2), .EDGE_MASK(32'h0010_0000)
    ) dut (
        .clk(clk),
        .arst(arst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake();
        bus.trap_ready = 1'b1;
        tick();
        bus.trap_ready = 1'b0;
    endtask

    task automatic chk_trap(input string tag, input logic [1:0] tgt, input logic [63:0] cause,
                            input logic [3:0] dc);
        chk({tag, ".valid"}, 64'(bus.trap_valid), 64'd1);
        chk({tag, ".target"}, 64'(bus.trap_target), 64'(tgt));
        chk({tag, ".cause"}, bus.trap_cause, cause);
        chk({tag, ".dcause"}, 64'(bus.trap_dcause), 64'(dc));
    endtask

    initial begin
        arst = 1'b1;
        bus.priv = M; bus.debug_mode = 0; bus.csr_mstatus_mie = 0; bus.csr_sstatus_sie = 0;
        bus.csr_mie = '0; bus.csr_mip_sw = '0; bus.csr_mideleg = '0; bus.csr_medeleg = '0;
        bus.irq = '0; bus.nmi = 0; bus.exc_valid = 0; bus.exc_cause = '0;
        bus.ebreak = 0; bus.instr_retire = 0; bus.haltreq = 0; bus.dcsr_step = 0;
        bus.dcsr_ebreakm = 0; bus.dcsr_ebreaks = 0; bus.dcsr_ebreaku = 0; bus.trap_ready = 0;
        tick();
        chk("rst.valid", 64'(bus.trap_valid), 64'd0);
        chk("rst.target", 64'(bus.trap_target), 64'(M));
        chk("rst.cause", bus.trap_cause, 64'd0);
        chk("rst.dcause", 64'(bus.trap_dcause), 64'd0);
        chk("rst.pending", 64'(bus.pending_o), 64'd0);
        arst = 1'b0;

        // Level MTI from user mode, held off by ready=0.
        bus.priv = U; bus.csr_mie[7] = 1'b1; bus.irq[7] = 1'b1;
        tick();
        chk("mti.early", 64'(bus.trap_valid), 64'd0);
        tick();
        chk("mti.pend", 64'(bus.pending_o[7]), 64'd1);
        chk("mti.nolat", 64'(bus.trap_valid), 64'd0);
        tick();
        chk_trap("mti", M, 64'h8000_0000_0000_0007, 4'd0);
        tick(3);
        chk_trap("mti.hold", M, 64'h8000_0000_0000_0007, 4'd0);
        handshake();
        bus.irq[7] = 1'b0; bus.csr_mie[7] = 1'b0;
        chk("mti.flush", 64'(bus.trap_valid), 64'd0);
        tick(2);
        chk("mti.idle", 64'(bus.trap_valid), 64'd0);

        // Delegated exception beats pending MEI; MEI follows after FLUSH.
        bus.priv = S; bus.csr_mip_sw[11] = 1'b1; bus.csr_mie[11] = 1'b1;
        bus.exc_valid = 1'b1; bus.exc_cause = 6'd13; bus.csr_medeleg[13] = 1'b1;
        tick();
        chk_trap("exc", S, 64'd13, 4'd0);
        bus.exc_valid = 1'b0;
        handshake();
        chk("exc.flush", 64'(bus.trap_valid), 64'd0);
        tick();
        chk("exc.idle", 64'(bus.trap_valid), 64'd0);
        tick();
        chk_trap("mei", M, 64'h8000_0000_0000_000B, 4'd0);
        handshake();
        bus.csr_mip_sw = '0; bus.csr_mie = '0; bus.csr_medeleg = '0;
        tick(2);

        // Edge-latched local cause 20.
        bus.priv = M; bus.csr_mstatus_mie = 1'b1;
        bus.irq[20] = 1'b1;
        tick();
        bus.irq[20] = 1'b0;
        chk("edge.t1", 64'(bus.pending_o[20]), 64'd0);
        tick();
        chk("edge.t2", 64'(bus.pending_o[20]), 64'd1);
        tick(3);
        chk("edge.kept", 64'(bus.pending_o[20]), 64'd1);
        chk("edge.masked", 64'(bus.trap_valid), 64'd0);
        bus.csr_mie[20] = 1'b1;
        tick();
        chk_trap("edge", M, 64'h8000_0000_0000_0014, 4'd0);
        handshake();
        chk("edge.clr", 64'(bus.pending_o[20]), 64'd0);
        bus.csr_mie[20] = 1'b0;
        tick(2);

        // MEI blocked in M with mie=0; NMI still taken.
        bus.csr_mstatus_mie = 1'b0; bus.csr_mie[11] = 1'b1; bus.irq[11] = 1'b1;
        tick(4);
        chk("mei.blk.pend", 64'(bus.pending_o[11]), 64'd1);
        chk("mei.blk", 64'(bus.trap_valid), 64'd0);
        bus.nmi = 1'b1;
        tick();
        bus.nmi = 1'b0;
        tick();
        chk("nmi.early", 64'(bus.trap_valid), 64'd0);
        tick();
        chk_trap("nmi", M, 64'h8000_0000_0000_0000, 4'd0);
        handshake();
        tick(2);
        chk("nmi.once", 64'(bus.trap_valid), 64'd0);
        bus.irq[11] = 1'b0; bus.csr_mie = '0;
        tick(3);

        // Single step on debug exit.
        bus.debug_mode = 1'b1; bus.dcsr_step = 1'b1;
        tick();
        bus.debug_mode = 1'b0;
        tick();
        chk("step.arm", 64'(bus.trap_valid), 64'd0);
        bus.instr_retire = 1'b1;
        tick();
        bus.instr_retire = 1'b0;
        chk_trap("step", D, 64'd0, 4'd4);
        handshake();
        tick(2);
        chk("step.done", 64'(bus.trap_valid), 64'd0);
        bus.dcsr_step = 1'b0;

        // haltreq beats exception.
        bus.haltreq = 1'b1; bus.exc_valid = 1'b1; bus.exc_cause = 6'd2;
        tick();
        chk_trap("halt", D, 64'd0, 4'd3);
        bus.haltreq = 1'b0; bus.exc_valid = 1'b0;
        handshake();
        tick();

        // In debug mode haltreq is masked but the exception is reported.
        bus.debug_mode = 1'b1; bus.haltreq = 1'b1; bus.exc_valid = 1'b1; bus.exc_cause = 6'd2;
        tick();
        chk_trap("dbgexc", M, 64'd2, 4'd0);
        bus.haltreq = 1'b0; bus.exc_valid = 1'b0;
        handshake();
        bus.debug_mode = 1'b0;
        tick();

        // ebreak in M with ebreakm enters debug.
        bus.ebreak = 1'b1; bus.dcsr_ebreakm = 1'b1;
        tick();
        chk_trap("ebreak", D, 64'd0, 4'd1);
        bus.ebreak = 1'b0; bus.dcsr_ebreakm = 1'b0;
        handshake();
        tick();

        // Async reset during HOLD.
        bus.exc_valid = 1'b1; bus.exc_cause = 6'd5;
        tick();
        chk("rsthold.pre", 64'(bus.trap_valid), 64'd1);
        #2 arst = 1'b1;
        #1;
        chk("rsthold.valid", 64'(bus.trap_valid), 64'd0);
        bus.exc_valid = 1'b0;
        tick();
        arst = 1'b0;
        tick(2);
        chk("rsthold.pend", 64'(bus.pending_o), 64'd0);
        chk("rsthold.idle", 64'(bus.trap_valid), 64'd0);
        chk("rsthold.cause", bus.trap_cause, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
